// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: multi-cycle two's-complement subtractor (D = A + ~B + 1).
// One 4-bit carry-lookahead slice is reused for WIDTH/4 cycles, LSB nibble
// first, with a carry register between cycles. There is a valid/ready
// handshake on both the input and the output side.
// Optional build macro SUB_ADD_MODE_EN: adds the op port (0 = subtract, 1 = add).
module nibble_serial_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             carry,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);

    localparam int N  = WIDTH / 4;
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] bp_reg;      // B as fed to the adder (inverted when subtracting)
    logic [WIDTH-1:0] diff_reg;
    logic [WIDTH-1:0] diff_next;   // diff_reg with the current nibble merged in
    logic             cin_reg;     // carry passed between nibble cycles
    logic [KW-1:0]    k_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             neg_reg;
    logic             zero_reg;

    logic             accept;
    logic             last_nibble;
    logic             is_sub;
    logic [KW+1:0]    base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       c;
    logic [3:0]       sum_nib;

`ifdef SUB_ADD_MODE_EN
    assign is_sub = ~op;
`else
    assign is_sub = 1'b1;
`endif

    assign accept      = in_valid && in_ready;
    assign last_nibble = (k_reg == KW'(N - 1));
    assign base        = {k_reg, 2'b00};
    assign a_nib       = a_reg[base +: 4];
    assign b_nib       = bp_reg[base +: 4];

    // 4-bit carry-lookahead slice: per-bit generate/propagate and sum.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cla_bit
            assign g[gi]       = a_nib[gi] & b_nib[gi];
            assign p[gi]       = a_nib[gi] ^ b_nib[gi];
            assign sum_nib[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Lookahead carries, all derived directly from the slice carry-in.
    assign c[0] = cin_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    // Merge the freshly computed nibble into the partial result.
    always_comb begin
        diff_next            = diff_reg;
        diff_next[base +: 4] = sum_nib;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_nibble) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, per-nibble accumulation and flag capture on the last nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            bp_reg    <= '0;
            diff_reg  <= '0;
            cin_reg   <= 1'b0;
            k_reg     <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            neg_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            if (accept) begin
                a_reg   <= a;
                bp_reg  <= is_sub ? ~b : b;
                cin_reg <= is_sub;
                k_reg   <= '0;
            end else if (state_reg == RUN) begin
                diff_reg <= diff_next;
                cin_reg  <= c[4];
                if (last_nibble) begin
                    k_reg     <= '0;
                    carry_reg <= c[4];
                    ovf_reg   <= (a_reg[WIDTH-1] == bp_reg[WIDTH-1]) &&
                                 (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
                    neg_reg   <= diff_next[WIDTH-1];
                    zero_reg  <= (diff_next == '0);
                end else begin
                    k_reg <= k_reg + KW'(1);
                end
            end
        end
    end

    assign diff  = diff_reg;
    assign carry = carry_reg;
    assign ovf   = ovf_reg;
    assign neg   = neg_reg;
    assign zero  = zero_reg;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Testbench for nibble_serial_sub (WIDTH = 32): directed table, corner
// sequences (backpressure, mid-operation reset) and random operands checked
// against an arithmetic reference model.
module tb_nibble_serial_sub;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         carry, ovf, neg, zero;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SUB_ADD_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .carry     (carry),
        .ovf       (ovf),
        .neg       (neg),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] diff;
        logic         carry;
        logic         ovf;
        logic         neg;
        logic         zero;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical values.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop,
                         output vec_t r);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (mop) begin
            ur = ua + ub;
            sr = sa + sb;
            r.carry = (ur >= 64'sd4294967296);
        end else begin
            ur = ua - ub;
            sr = sa - sb;
            r.carry = (ua >= ub);
        end
        r.a    = ma;
        r.b    = mb;
        r.op   = mop;
        r.diff = ur[W-1:0];
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.neg  = r.diff[W-1];
        r.zero = (r.diff == '0);
    endtask

    // Present one operation and wait (bounded) for out_valid; returns at a negedge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                            output int lat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        a = ta;
        b = tb_v;
        op = top;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        check("in_ready_run", in_ready, 0);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic check_result(input string tag, input vec_t e, input int lat);
        check({tag, "_latency"}, lat, 8);
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_diff"}, diff, e.diff);
        check({tag, "_carry"}, carry, e.carry);
        check({tag, "_ovf"}, ovf, e.ovf);
        check({tag, "_neg"}, neg, e.neg);
        check({tag, "_zero"}, zero, e.zero);
        $display("op a=%h b=%h op=%0d -> diff=%h c=%0d v=%0d n=%0d z=%0d lat=%0d",
                 e.a, e.b, e.op, diff, carry, ovf, neg, zero, lat);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_diff"}, diff, 0);
        check({tag, "_carry"}, carry, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_neg"}, neg, 0);
        check({tag, "_zero"}, zero, 0);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t e;
        vec_t hold;
        int   lat;

        vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0});
`ifdef SUB_ADD_MODE_EN
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0});
`endif

        // Reset state.
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            finish_op();
        end

        // Backpressure: result held, in_valid pulses ignored while in DONE.
        model(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, hold);
        start_op(hold.a, hold.b, 1'b0, lat);
        check_result("bp", hold, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_in_ready", in_ready, 0);
            check("bp_hold_diff", diff, hold.diff);
            check("bp_hold_flags", {carry, ovf, neg, zero}, {hold.carry, hold.ovf, hold.neg, hold.zero});
        end
        in_valid = 1'b0;
        finish_op();
        $display("backpressure sequence done");

        // Reset in the middle of RUN (k = 3), then the same operation again.
        @(negedge clk);
        a = 32'd9;
        b = 32'd4;
        op = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model(32'd9, 32'd4, 1'b0, e);
        start_op(32'd9, 32'd4, 1'b0, lat);
        check_result("after_reset", e, lat);
        check("after_reset_diff5", diff, 32'd5);
        finish_op();

        // Reset while in DONE.
        start_op(32'd100, 32'd1, 1'b0, lat);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("done_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Random operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            logic         rop;
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : $urandom;
            if (i % 5 == 1) ra[31] = ~rb[31] ^ ra[30];
`ifdef SUB_ADD_MODE_EN
            rop = 1'($urandom_range(0, 1));
`else
            rop = 1'b0;
`endif
            model(ra, rb, rop, e);
            start_op(ra, rb, rop, lat);
            check_result($sformatf("rnd%0d", i), e, lat);
            finish_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_sub.md
# nibble_serial_sub

Multi-cycle two's-complement subtractor for the FPU datapath, built around one 4-bit carry-lookahead slice reused across WIDTH/4 cycles. Computes D = A − B as A + ~B + 1, one nibble per cycle, LSB first, with a carry register between cycles. Used for exponent difference and mantissa subtraction where area matters more than latency. Valid/ready handshake on both the input and output sides.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 4 and at least 8. N = WIDTH/4 nibble cycles.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A, B (and op, if present) are presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- op  input  1  only with SUB_ADD_MODE_EN: 0 = subtract, 1 = add.
- out_valid  output  1  result and flags are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  result.
- carry  output  1  raw carry out of the MSB nibble. Subtract: 1 ⇔ A ≥ B unsigned.
- ovf  output  1  signed overflow.
- neg  output  1  diff[WIDTH-1].
- zero  output  1  diff == 0.

## Operation
- States:
  - IDLE: in_ready = 1.
  - RUN: nibble counter k = 0..N−1.
  - DONE: out_valid = 1.
- IDLE→RUN on in_valid && in_ready.
  - Latch A and B' (B' = ~B for subtract, B for add).
  - Carry register ← 1 for subtract, 0 for add.
  - k ← 0.
- RUN, each cycle:
  - Nibble k of A and B', plus the carry register, go through the 4-bit CLA slice.
  - Sum nibble is written into diff[4k+3:4k]; carry register ← slice carry out; k ← k+1.
  - When k = N−1, go to DONE.
- DONE: diff and all flags are held stable. DONE→IDLE on out_ready.
- Flags are registered on entry to DONE:
  - carry = final carry.
  - ovf = (A[msb] == B'[msb]) && (diff[msb] != A[msb]).
  - neg = diff[msb].
  - zero = (diff == 0).
- in_valid is ignored outside IDLE. Operand pins may change freely after acceptance.
- diff and the flags are only defined while out_valid = 1. The bench checks them only then, except at reset.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, diff 0, carry 0, ovf 0, neg 0, zero 0, k 0.
- Latency: acceptance at edge E0 → nibbles processed at edges E1..EN → out_valid high after edge EN (N cycles; 8 for WIDTH=32).
- out_valid stays high until the edge where out_ready = 1. It falls after that edge.
- in_ready rises in the cycle after the output transfer. There is no same-cycle accept/complete overlap.
- Throughput: at most one operation per N+2 cycles.
- out_ready while not out_valid: ignored.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately, all outputs go to their reset values, and no partial result is presented.
- The first accept after reset release behaves normally.

## Configuration
- SUB_ADD_MODE_EN:
  - Defined: the op port exists. op is sampled at acceptance and selects add or subtract; carry-in and B' are chosen as described in Operation.
  - Undefined: the op port is absent and the block subtracts only.
- Latency and flag definitions are identical in both builds.

## Test plan
- a=5, b=3 → after 8 cycles: diff=0x00000002, carry=1, ovf=0, neg=0, zero=0.
- a=3, b=5 → diff=0xFFFFFFFE, carry=0, neg=1, ovf=0, zero=0.
- a=0x80000000, b=1 → diff=0x7FFFFFFF, ovf=1, carry=1, neg=0. Also a=0x12345678, b=0x12345678 → diff=0, zero=1, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → diff and flags stable, in_ready=0, extra in_valid pulses ignored. Then out_ready=1 → out_valid falls next edge and in_ready=1 the following cycle.
- Reset: assert rst_n=0 at k=3 of a=9, b=4 → all outputs at reset values. After release, a=9, b=4 again → diff=5 exactly 8 cycles after accept.
- With SUB_ADD_MODE_EN: op=1, a=0xFFFFFFFF, b=1 → diff=0, carry=1, zero=1, ovf=0. Also op=1, a=0x7FFFFFFF, b=1 → diff=0x80000000, ovf=1.
